fifo_wr_ctrl: RTL and testbench
===============================

Name: fifo_wr_ctrl

Overview:
Write-domain pointer and flag controller for the asynchronous FIFO. It sits directly upstream of the dual-port FIFO memory and drives that memory's write enable, write address and full inputs. It keeps the write pointer in binary and Gray form and exports the Gray pointer to the read domain. It synchronizes the read-domain Gray pointer and derives full, almost_full, fill level and a sticky overflow flag.

Parameters:
DEPTH, 16, FIFO entries; power of two, >= 4; must equal the memory's DEPTH
ALMOST_FULL_THRESH, 14, level at or above which almost_full asserts; range 1..DEPTH
SYNC_STAGES, 2, flop stages on the incoming read pointer; >= 2
(localparam ADDRSIZE = clog2(DEPTH); PTRSIZE = ADDRSIZE+1)

Ports:
wr_clk  input  1  write-domain clock; the block's only clock
wr_rst  input  1  synchronous, active-high reset
wr_req  input  1  upstream write request; data is presented to the memory alongside
ovf_clr  input  1  clears sticky overflow
rd_ptr_gray  input  PTRSIZE  read pointer in Gray code from read domain; asynchronous to wr_clk
wr_en  output  1  to memory: wr_req & ~full & ~wr_rst (combinational)
wr_addr  output  ADDRSIZE  to memory: wbin[ADDRSIZE-1:0]
full  output  1  registered full flag; also fed to memory
almost_full  output  1  registered, level >= ALMOST_FULL_THRESH
wr_level  output  PTRSIZE  registered occupancy as seen by the write side, 0..DEPTH
wr_ptr_gray  output  PTRSIZE  registered Gray write pointer to the read-domain synchronizer
overflow  output  1  sticky; wr_req seen while full

Behaviour:
- Reset (wr_rst=1 at a wr_clk edge) has priority over all other activity. It zeroes wbin, wr_ptr_gray, all sync stages, full, almost_full, wr_level and overflow.
- While wr_rst=1, wr_en=0 regardless of wr_req.
- The read domain must be reset together with this block. A mid-operation reset discards all pointer history.
- Sync chain: rd_ptr_gray passes through SYNC_STAGES flops to produce rq_sync. Gray coding ensures only one bit changes per read advance.
- Pointer update, on each edge:
  - wbin_next = wbin + wr_en (mod 2^PTRSIZE)
  - gray_next = (wbin_next >> 1) ^ wbin_next
  - wbin <= wbin_next; wr_ptr_gray <= gray_next
- Full:
  - full <= (gray_next == {~rq_sync[MSB:MSB-1], rq_sync[MSB-2:0]})
  - full asserts on the same edge that commits the DEPTH-th outstanding write.
- Level:
  - rbin_sync = gray-to-binary(rq_sync)
  - wr_level <= wbin_next - rbin_sync, computed in PTRSIZE bits, mod 2^PTRSIZE
  - almost_full <= (wbin_next - rbin_sync) >= ALMOST_FULL_THRESH
- Latency:
  - Write: wr_en is combinational, so wr_addr is consumed by the memory at the same edge.
  - Flags: full, level and almost_full reflect the write at the following output.
  - Read advance: a rd_ptr_gray change stable before edge k is reflected in full/wr_level/almost_full after edge k+SYNC_STAGES, i.e. SYNC_STAGES+1 edges.
- Pessimism: full and level are conservative (stale read pointer). The FIFO never overwrites unread data.
- Full + wr_req:
  - no write; wbin unchanged
  - overflow <= 1 on that edge
- overflow:
  - cleared by ovf_clr=1 when no new overflow event occurs that cycle
  - if a set event and ovf_clr coincide, set wins
- Full release and wr_req in the same cycle: full is still the registered value, so there is no write that cycle. The write proceeds on the next cycle.
- Wrap-around:
  - wr_addr wraps DEPTH-1 -> 0.
  - The pointer MSB toggles every DEPTH writes.
  - wr_ptr_gray changes exactly one bit per write, including across the 2^PTRSIZE-1 -> 0 wrap.
- wr_ptr_gray is a flop output with no combinational path, so it is safe to cross domains.

Test Plan:
1. Reset: hold wr_rst=1 for 2 cycles with wr_req=1, rd_ptr_gray=0 -> wr_en=0 throughout; after reset all outputs are 0 and wr_addr=0.
2. Fill: rd_ptr_gray=0, wr_req=1 for 16 cycles ->
   - wr_addr steps 0..15
   - almost_full goes 1 after the 14th write
   - full goes 1 after the 16th write
   - wr_level=16, wr_ptr_gray=5'b11000
3. Overflow: from full, wr_req=1 for 1 cycle -> wr_en=0, wr_addr stays 0, overflow=1 and stays 1. Then ovf_clr=1 for 1 cycle -> overflow=0. Then wr_req=1 and ovf_clr=1 in the same cycle -> overflow=1.
4. Release: from full, drive rd_ptr_gray=5'b00001 -> full stays 1 for 2 edges, falls after the 3rd edge; wr_level=15 and almost_full=1 at that point.
5. Wrap: the reader model tracks the writer with a 4-entry lag across 40 writes ->
   - wr_addr sequence wraps 15->0 twice
   - every wr_ptr_gray transition has Hamming distance 1
   - full never asserts
   - wr_level is constant at 4+SYNC_STAGES-related lag, matching the model
6. Simultaneous: full=1, rd_ptr_gray advances and wr_req=1 is held -> no write until the cycle after full falls; then wr_en=1 and wr_addr=0; full reasserts after that write.

Source files
------------

// File: rtl/fifo_wr_ctrl.sv
// Write-side pointer/flag controller for the async FIFO: binary+Gray write pointer, read-pointer sync, full/level flags.
// Latency: wr_en/wr_addr combinational to the memory; flags update one edge after a write, SYNC_STAGES+1 edges after a read advance.
// Backpressure: full (registered) blocks writes; a request while full is dropped and latches the sticky overflow flag.
//
// Ports:
//   wr_clk, wr_rst      write-domain clock, synchronous active-high reset
//   wr_req, ovf_clr     upstream write request, sticky-overflow clear
//   rd_ptr_gray         read pointer (Gray) from the read domain, asynchronous
//   wr_en, wr_addr      memory write enable and address
//   full, almost_full   registered occupancy flags
//   wr_level            registered occupancy 0..DEPTH as seen from the write side
//   wr_ptr_gray         registered Gray write pointer toward the read domain
//   overflow            sticky: request seen while full
module fifo_wr_ctrl #(
  parameter int DEPTH              = 16,
  parameter int ALMOST_FULL_THRESH = 14,
  parameter int SYNC_STAGES        = 2,
  localparam int ADDRSIZE          = $clog2(DEPTH),
  localparam int PTRSIZE           = ADDRSIZE + 1
) (
  input  logic                wr_clk,
  input  logic                wr_rst,
  input  logic                wr_req,
  input  logic                ovf_clr,
  input  logic [PTRSIZE-1:0]  rd_ptr_gray,
  output logic                wr_en,
  output logic [ADDRSIZE-1:0] wr_addr,
  output logic                full,
  output logic                almost_full,
  output logic [PTRSIZE-1:0]  wr_level,
  output logic [PTRSIZE-1:0]  wr_ptr_gray,
  output logic                overflow
);

  localparam logic [PTRSIZE-1:0] AF_THRESH = PTRSIZE'(ALMOST_FULL_THRESH);

  logic [PTRSIZE-1:0] wbin;
  logic [PTRSIZE-1:0] wbin_next;
  logic [PTRSIZE-1:0] gray_next;
  logic [PTRSIZE-1:0] sync_q [SYNC_STAGES];
  logic [PTRSIZE-1:0] rq_sync;
  logic [PTRSIZE-1:0] rbin_sync;
  logic [PTRSIZE-1:0] level_next;
  logic [PTRSIZE-1:0] full_pattern;
  logic               ovf_set;

  // Reset gates the enable so the memory never sees a write during reset.
  assign wr_en   = wr_req & ~full & ~wr_rst;
  assign wr_addr = wbin[ADDRSIZE-1:0];
  assign ovf_set = wr_req & full;

  // Read pointer crosses into this domain only through this flop chain.
  always_ff @(posedge wr_clk) begin
    if (wr_rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= rd_ptr_gray;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign rq_sync = sync_q[SYNC_STAGES-1];

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    rbin_sync = '0;
    for (int i = 0; i < PTRSIZE; i++) rbin_sync[i] = ^(rq_sync >> i);
  end

  assign wbin_next  = wbin + {{(PTRSIZE-1){1'b0}}, wr_en};
  assign gray_next  = (wbin_next >> 1) ^ wbin_next;
  assign level_next = wbin_next - rbin_sync;

  // In Gray space "one lap ahead" means the top two bits inverted, rest equal.
  assign full_pattern = {~rq_sync[PTRSIZE-1:PTRSIZE-2], rq_sync[PTRSIZE-3:0]};

  always_ff @(posedge wr_clk) begin
    if (wr_rst) begin
      wbin        <= '0;
      wr_ptr_gray <= '0;
      full        <= 1'b0;
      almost_full <= 1'b0;
      wr_level    <= '0;
      overflow    <= 1'b0;
    end else begin
      wbin        <= wbin_next;
      wr_ptr_gray <= gray_next;
      full        <= (gray_next == full_pattern);
      almost_full <= (level_next >= AF_THRESH);
      wr_level    <= level_next;
      // A new overflow event wins over a simultaneous clear.
      if (ovf_set)      overflow <= 1'b1;
      else if (ovf_clr) overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
module tb_fifo_wr_ctrl;

  localparam int DEPTH  = 16;
  localparam int AF_TH  = 14;
  localparam int SYNC_N = 2;
  localparam int PTRW   = 5;

  logic            wr_clk;
  logic            wr_rst;
  logic            wr_req;
  logic            ovf_clr;
  logic [PTRW-1:0] rd_ptr_gray;
  logic            wr_en;
  logic [3:0]      wr_addr;
  logic            full;
  logic            almost_full;
  logic [PTRW-1:0] wr_level;
  logic [PTRW-1:0] wr_ptr_gray;
  logic            overflow;

  fifo_wr_ctrl #(.DEPTH(DEPTH), .ALMOST_FULL_THRESH(AF_TH), .SYNC_STAGES(SYNC_N)) dut (
    .wr_clk(wr_clk), .wr_rst(wr_rst), .wr_req(wr_req), .ovf_clr(ovf_clr),
    .rd_ptr_gray(rd_ptr_gray), .wr_en(wr_en), .wr_addr(wr_addr), .full(full),
    .almost_full(almost_full), .wr_level(wr_level), .wr_ptr_gray(wr_ptr_gray),
    .overflow(overflow)
  );

  initial wr_clk = 1'b0;
  always #5 wr_clk = ~wr_clk;

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: total writes and reads as unbounded counts.
  int wr_count = 0;
  int rd_count = 0;
  int seen_q[$];     // reader counts as captured at past edges, oldest first
  bit m_full = 0;
  bit m_af   = 0;
  bit m_ovf  = 0;
  int m_level = 0;
  bit last_wr = 0;
  bit any_full = 0;
  int addr_wraps = 0;
  logic [PTRW-1:0] prev_gray;

  function automatic logic [PTRW-1:0] to_gray(input int n);
    logic [PTRW-1:0] b;
    b = PTRW'(n % (1 << PTRW));
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    wr_count = 0;
    rd_count = 0;
    seen_q.delete();
    for (int i = 0; i < SYNC_N; i++) seen_q.push_back(0);
    m_full = 0; m_af = 0; m_ovf = 0; m_level = 0;
  endtask

  // One clock cycle: drive at negedge, check combinational outputs, take the edge,
  // advance the model, then check registered outputs.
  task automatic step(input bit req, input bit clr, input bit rst_i);
    bit exp_en;
    int rsync;
    wr_req      = req;
    ovf_clr     = clr;
    wr_rst      = rst_i;
    rd_ptr_gray = to_gray(rd_count);
    prev_gray   = wr_ptr_gray;
    #1;
    exp_en = req && !m_full && !rst_i;
    chk("wr_en", 32'(wr_en), 32'(exp_en));
    chk("wr_addr", 32'(wr_addr), 32'(wr_count % DEPTH));
    if (exp_en && (wr_count % DEPTH) == DEPTH - 1) addr_wraps++;
    @(posedge wr_clk);
    if (rst_i) begin
      model_reset();
      last_wr = 0;
    end else begin
      rsync = seen_q.pop_front();
      seen_q.push_back(rd_count);
      if (req && m_full) m_ovf = 1;
      else if (clr)      m_ovf = 0;
      wr_count += int'(exp_en);
      m_level = wr_count - rsync;
      m_full  = (m_level == DEPTH);
      m_af    = (m_level >= AF_TH);
      last_wr = exp_en;
    end
    #1;
    chk("full", 32'(full), 32'(m_full));
    chk("almost_full", 32'(almost_full), 32'(m_af));
    chk("wr_level", 32'(wr_level), 32'(m_level));
    chk("wr_ptr_gray", 32'(wr_ptr_gray), 32'(to_gray(wr_count)));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    if (last_wr) chk("gray_hamming", 32'($countones(wr_ptr_gray ^ prev_gray)), 32'd1);
    if (full === 1'b1) any_full = 1;
    @(negedge wr_clk);
  endtask

  initial begin
    // Bring flops out of X before the first checked cycle.
    wr_rst = 1'b1; wr_req = 1'b0; ovf_clr = 1'b0; rd_ptr_gray = '0;
    model_reset();
    @(posedge wr_clk);
    @(negedge wr_clk);

    // Reset held two cycles with a pending request.
    step(1, 0, 1);
    step(1, 0, 1);
    chk("rst_level", 32'(wr_level), 32'd0);
    chk("rst_addr", 32'(wr_addr), 32'd0);

    // Fill with no reads.
    for (int i = 0; i < DEPTH; i++) begin
      step(1, 0, 0);
      if (i == AF_TH - 2) chk("af_before_14th", 32'(almost_full), 32'd0);
      if (i == AF_TH - 1) chk("af_after_14th", 32'(almost_full), 32'd1);
      if (i == DEPTH - 2) chk("full_before_16th", 32'(full), 32'd0);
    end
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_level", 32'(wr_level), 32'd16);
    chk("fill_gray", 32'(wr_ptr_gray), 32'b11000);

    // Overflow while full, clear, then set-and-clear together.
    step(1, 0, 0);
    chk("ovf_set", 32'(overflow), 32'd1);
    chk("ovf_addr", 32'(wr_addr), 32'd0);
    step(0, 0, 0);
    chk("ovf_sticky", 32'(overflow), 32'd1);
    step(0, 1, 0);
    chk("ovf_clr", 32'(overflow), 32'd0);
    step(1, 1, 0);
    chk("ovf_set_wins", 32'(overflow), 32'd1);

    // Release: one read becomes visible after SYNC_N+1 edges.
    rd_count = 1;
    step(0, 0, 0);
    chk("rel_full_e1", 32'(full), 32'd1);
    step(0, 0, 0);
    chk("rel_full_e2", 32'(full), 32'd1);
    step(0, 0, 0);
    chk("rel_full_e3", 32'(full), 32'd0);
    chk("rel_level", 32'(wr_level), 32'd15);
    chk("rel_af", 32'(almost_full), 32'd1);

    // Wrap: reader trails the writer by four entries.
    step(0, 0, 1);
    addr_wraps = 0;
    any_full = 0;
    for (int i = 0; i < 40; i++) begin
      rd_count = (wr_count > 4) ? wr_count - 4 : 0;
      step(1, 1, 0);
    end
    chk("wrap_count", 32'(addr_wraps), 32'd2);
    chk("wrap_no_full", 32'(any_full), 32'd0);

    // Simultaneous release and held request.
    step(0, 0, 1);
    for (int i = 0; i < DEPTH; i++) step(1, 0, 0);
    rd_count = 1;
    step(1, 0, 0);
    step(1, 0, 0);
    step(1, 0, 0);
    chk("sim_full_fell", 32'(full), 32'd0);
    wr_req = 1'b1; ovf_clr = 1'b0; wr_rst = 1'b0;
    #1;
    chk("sim_wr_en", 32'(wr_en), 32'd1);
    chk("sim_wr_addr", 32'(wr_addr), 32'd0);
    step(1, 0, 0);
    chk("sim_full_again", 32'(full), 32'd1);

    // Random traffic with occasional reads and rare resets.
    step(0, 0, 1);
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        rd_count = 0;
        step(1, 0, 1);
      end else begin
        if ($urandom_range(0, 2) == 0 && rd_count < wr_count) rd_count++;
        step($urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0, 0);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
